shared_reg_arbiter: RTL

- Shares one DATA_W-bit D-flip-flop storage register between NUM_REQ requesters using round-robin arbitration.
- Each cycle it picks at most one requesting source, loads that source's data into the shared register and returns a one-hot grant.
- It sits in front of the flip-flop datapath as its write scheduler, so several producers can update one register without contention.

---
 rtl/shared_reg_arbiter_pkg.sv | 25 ++
 rtl/shared_reg_arbiter_rr_pick.sv | 36 +++
 rtl/shared_reg_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register round-robin arbiter:
// FSM state encoding, default sizing and a one-hot to index helper.
package shared_reg_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_DATA_W  = 8;

   // Converts a one-hot vector (up to 16 requesters) to its bit index.
   // An all-zero vector maps to index 0.
   function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin selector: the winner is the first requester
// found when searching upward from ptr with wrap-around.
module rr_pick
   import shared_reg_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               any_req
);

   logic [NUM_REQ-1:0] oh;

   // Rotating search from ptr; only the first hit sets its one-hot bit.
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] idx;
      oh    = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            oh[idx] = 1'b1;
            found   = 1'b1;
         end
      end
   end

   assign any_req = |req;
   assign winner  = IDX_W'(onehot_to_idx(16'(oh)));

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write scheduler for one shared DATA_W-bit register.
// Each cycle at most one requester is selected; its data is loaded into q
// and a one-hot grant is presented the following cycle.
// Optional feature macro: SHARED_REG_LOCK_EN (adds the lock port and the
// LOCKED state, which keeps granting the owner while it holds req and lock).
module shared_reg_arbiter
   import shared_reg_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   parameter  int DATA_W  = DEF_DATA_W,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
`ifdef SHARED_REG_LOCK_EN
   input  logic [NUM_REQ-1:0]        lock,
`endif
   output logic [NUM_REQ-1:0]        gnt,
   output logic [DATA_W-1:0]         q,
   output logic                      q_valid,
   output logic [IDX_W-1:0]          owner
);

   arb_state_t       state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;
   logic [IDX_W-1:0] pick_idx, sel_idx;
   logic             pick_any, sel_vld;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req     (req),
      .ptr     (ptr),
      .winner  (pick_idx),
      .any_req (pick_any)
   );

   // Select this edge's winner and the next FSM state.
   always_comb begin
      sel_vld   = pick_any;
      sel_idx   = pick_idx;
      state_nxt = IDLE;
`ifdef SHARED_REG_LOCK_EN
      // A held lock bypasses round-robin; dropping req or lock falls back
      // to normal arbitration from ptr, which already points at owner+1.
      if (state == LOCKED && req[owner] && lock[owner]) begin
         sel_vld = 1'b1;
         sel_idx = owner;
      end
`endif
      if (sel_vld) begin
         state_nxt = GRANT;
`ifdef SHARED_REG_LOCK_EN
         if (lock[sel_idx]) state_nxt = LOCKED;
`endif
      end
      ptr_nxt = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
   end

   // State, priority pointer and the shared register with its owner tag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         ptr     <= '0;
         q       <= '0;
         q_valid <= 1'b0;
         owner   <= '0;
      end else begin
         state <= state_nxt;
         if (sel_vld) begin
            q       <= wdata[sel_idx*DATA_W +: DATA_W];
            owner   <= sel_idx;
            q_valid <= 1'b1;
            ptr     <= ptr_nxt;
         end
      end
   end

   // Grant is a pure decode of registered state and owner, so it is one-hot
   // by construction and clears together with the state on reset.
   always_comb begin
      gnt = '0;
      if (state != IDLE) gnt[owner] = 1'b1;
   end

endmodule
